fp16_align_ctrl: RTL and testbench

FP16_ALIGN_CTRL -- requirements
Module: fp16_align_ctrl

---
 rtl/fp16_align_ctrl_if.sv | 31 +++
 rtl/fp16_align_ctrl.sv | 139 +++++++++++++
 tb/tb_fp16_align_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/fp16_align_ctrl_if.sv
// Operand/result handshake bundle for fp16_align_ctrl.
// slave = alignment block side, master = the upstream/downstream environment.
interface fp16_align_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a;
  logic [15:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic        out_big_sign;
  logic        out_small_sign;
  logic [4:0]  out_big_exp;
  logic [15:0] out_big_man;
  logic [15:0] out_small_man;
  logic [3:0]  out_shift;
  logic        out_flush;
  logic        out_eff_sub;
  logic        out_sticky;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_big_sign, out_small_sign, out_big_exp,
           out_big_man, out_small_man, out_shift, out_flush, out_eff_sub, out_sticky
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_big_sign, out_small_sign, out_big_exp,
           out_big_man, out_small_man, out_shift, out_flush, out_eff_sub, out_sticky
  );
endinterface

// File: rtl/fp16_align_ctrl.sv
// FP16 add-path operand alignment: 2-stage compare/swap then shift/flush decode.
// Optional sticky generation enabled by defining FP16_ALIGN_STICKY_EN.

module fp16_unpack (
  input  logic [15:0] op,
  output logic [4:0]  eff_exp,
  output logic [15:0] man
);
  logic hid;
  assign hid     = |op[14:10];
  // Subnormals share exponent 1 with the smallest normals.
  assign eff_exp = hid ? op[14:10] : 5'd1;
  assign man     = {hid, op[9:0], 5'b0};
endmodule

module fp16_align_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  fp16_align_ctrl_if.slave   bus
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic        big_sign;
    logic        small_sign;
    logic [4:0]  big_exp;
    logic [15:0] big_man;
    logic [15:0] small_man;
    logic [4:0]  diff;
  } s1_t;

  typedef struct packed {
    logic        big_sign;
    logic        small_sign;
    logic [4:0]  big_exp;
    logic [15:0] big_man;
    logic [15:0] small_man;
    logic [3:0]  shift;
    logic        flush;
    logic        eff_sub;
  } s2_t;

  logic [STAGES:1]   vld_pipe;
  logic              s1_adv, s2_adv;
  s1_t               s1_d, s1_q;
  s2_t               s2_d, s2_q;

  logic [1:0][15:0]  ops;
  logic [1:0][4:0]   eff;
  logic [1:0][15:0]  man;
  logic              a_big;

  assign ops = {bus.in_b, bus.in_a};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_unp
      fp16_unpack u_unp (.op(ops[i]), .eff_exp(eff[i]), .man(man[i]));
    end
  endgenerate

  // Exponent-then-mantissa magnitude order; a full tie keeps in_a as big.
  assign a_big = {eff[0], man[0]} >= {eff[1], man[1]};

  always_comb begin
    s1_d = '0;
    if (a_big) begin
      s1_d.big_sign   = ops[0][15];
      s1_d.small_sign = ops[1][15];
      s1_d.big_exp    = ops[0][14:10];
      s1_d.big_man    = man[0];
      s1_d.small_man  = man[1];
      s1_d.diff       = eff[0] - eff[1];
    end else begin
      s1_d.big_sign   = ops[1][15];
      s1_d.small_sign = ops[0][15];
      s1_d.big_exp    = ops[1][14:10];
      s1_d.big_man    = man[1];
      s1_d.small_man  = man[0];
      s1_d.diff       = eff[1] - eff[0];
    end
  end

  always_comb begin
    s2_d            = '0;
    s2_d.big_sign   = s1_q.big_sign;
    s2_d.small_sign = s1_q.small_sign;
    s2_d.big_exp    = s1_q.big_exp;
    s2_d.big_man    = s1_q.big_man;
    s2_d.flush      = s1_q.diff[4];
    s2_d.shift      = s1_q.diff[4] ? 4'd15 : s1_q.diff[3:0];
    s2_d.small_man  = s1_q.diff[4] ? 16'h0000 : s1_q.small_man;
    s2_d.eff_sub    = s1_q.big_sign ^ s1_q.small_sign;
  end

  assign s2_adv       = !vld_pipe[2] || bus.out_ready;
  assign s1_adv       = !vld_pipe[1] || s2_adv;
  assign bus.in_ready = s1_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
    end else begin
      if (s1_adv)                  vld_pipe[1] <= bus.in_valid;
      if (s1_adv && bus.in_valid)  s1_q        <= s1_d;
      if (s2_adv)                  vld_pipe[2] <= vld_pipe[1];
      if (s2_adv && vld_pipe[1])   s2_q        <= s2_d;
    end
  end

`ifdef FP16_ALIGN_STICKY_EN
  logic [15:0] stk_mask;
  logic        sticky_d, sticky_q;

  // Bits below the shift point are lost; on flush the whole mantissa is lost.
  assign stk_mask = (16'h0001 << s2_d.shift) - 16'h0001;
  assign sticky_d = s2_d.flush ? |s1_q.small_man : |(s1_q.small_man & stk_mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                     sticky_q <= 1'b0;
    else if (s2_adv && vld_pipe[1]) sticky_q <= sticky_d;
  end

  assign bus.out_sticky = sticky_q;
`else
  assign bus.out_sticky = 1'b0;
`endif

  assign bus.out_valid      = vld_pipe[2];
  assign bus.out_big_sign   = s2_q.big_sign;
  assign bus.out_small_sign = s2_q.small_sign;
  assign bus.out_big_exp    = s2_q.big_exp;
  assign bus.out_big_man    = s2_q.big_man;
  assign bus.out_small_man  = s2_q.small_man;
  assign bus.out_shift      = s2_q.shift;
  assign bus.out_flush      = s2_q.flush;
  assign bus.out_eff_sub    = s2_q.eff_sub;
endmodule

// File: tb/tb_fp16_align_ctrl.sv
// Scoreboard bench for fp16_align_ctrl: driver pushes expected results, monitor pops on transfer.
module tb_fp16_align_ctrl;
`ifdef FP16_ALIGN_STICKY_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  typedef struct {
    logic        bs, ss;
    logic [4:0]  be;
    logic [15:0] bm, sm;
    logic [3:0]  sh;
    logic        fl, es, st;
    bit          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;
  bit   presented = 0;
  exp_t q[$];

  fp16_align_ctrl_if bus();

  fp16_align_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(logic bs, logic ss, logic [4:0] be, logic [15:0] bm,
                              logic [15:0] sm, logic [3:0] sh, logic fl, logic es, logic st);
    exp_t e;
    e.bs = bs; e.ss = ss; e.be = be; e.bm = bm; e.sm = sm;
    e.sh = sh; e.fl = fl; e.es = es; e.st = st & STK;
    e.lat = 1'b0; e.acc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, want %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1; holds in_valid until the pair is accepted.
  task automatic send(input logic [15:0] a, input logic [15:0] b, input exp_t e, input bit lat);
    bus.in_a = a; bus.in_b = b; bus.in_valid = 1'b1;
    for (int t = 0; t < 50 && !bus.in_ready; t++) begin @(posedge clk); #1; end
    if (!bus.in_ready) chk("send_timeout", 0, 1);
    e.lat = lat;
    e.acc = cyc + 2;
    q.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 50 && q.size() != 0; t++) @(posedge clk);
    chk("drain_left", q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    bus.in_valid = 1'b0; bus.in_a = 16'h0; bus.in_b = 16'h0; bus.out_ready = 1'b1;
    fork
      begin : mon
        forever begin
          @(negedge clk);
          if (rst_n && bus.out_valid) begin
            if (q.size() == 0) begin
              chk("unexpected_out", 1, 0);
            end else begin
              e = q[0];
              if (!presented && e.lat) chk("latency", cyc, e.acc);
              presented = 1;
              chk("big_sign",   bus.out_big_sign,   e.bs);
              chk("small_sign", bus.out_small_sign, e.ss);
              chk("big_exp",    bus.out_big_exp,    e.be);
              chk("big_man",    bus.out_big_man,    e.bm);
              chk("small_man",  bus.out_small_man,  e.sm);
              chk("shift",      bus.out_shift,      e.sh);
              chk("flush",      bus.out_flush,      e.fl);
              chk("eff_sub",    bus.out_eff_sub,    e.es);
              chk("sticky",     bus.out_sticky,     e.st);
              if (bus.out_ready) begin
                void'(q.pop_front());
                presented = 0;
              end
            end
          end
        end
      end
      begin : wdog
        repeat (20000) @(posedge clk);
        chk("watchdog_expired", 1, 0);
      end
      begin : drv
        #3;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_small_man", bus.out_small_man, 0);
        chk("rst_big_exp", bus.out_big_exp, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic, swap, flush and sticky vectors, each with latency checked.
        send(16'h3C00, 16'h3800, mk(0,0,5'd15,16'h8000,16'h8000,4'd1,0,0,0), 1); drain();
        send(16'h3800, 16'hC000, mk(1,0,5'd16,16'h8000,16'h8000,4'd2,0,1,0), 1); drain();
        send(16'h7800, 16'h0400, mk(0,0,5'd30,16'h8000,16'h0000,4'd15,1,0,1), 1); drain();
        send(16'h5400, 16'h3C01, mk(0,0,5'd21,16'h8000,16'h8020,4'd6,0,0,1), 1); drain();

        // Back-to-back stream: tie, subnormals, diff 16, diff 15, same-exp swap.
        send(16'h4500, 16'h4500, mk(0,0,5'd17,16'hA000,16'hA000,4'd0,0,0,0), 1);
        send(16'h0001, 16'h8200, mk(1,0,5'd0,16'h4000,16'h0020,4'd0,0,1,0), 1);
        send(16'h4400, 16'h0400, mk(0,0,5'd17,16'h8000,16'h0000,4'd15,1,0,1), 1);
        send(16'h4000, 16'h0401, mk(0,0,5'd16,16'h8000,16'h8020,4'd15,0,0,1), 1);
        send(16'h3C00, 16'hBC01, mk(1,0,5'd15,16'h8020,16'h8000,4'd0,0,1,0), 1);
        drain();

        // Backpressure: two accepts fill the pipe, third waits, then stream out.
        bus.out_ready = 1'b0;
        send(16'h3C00, 16'h3800, mk(0,0,5'd15,16'h8000,16'h8000,4'd1,0,0,0), 1);
        send(16'h3800, 16'hC000, mk(1,0,5'd16,16'h8000,16'h8000,4'd2,0,1,0), 0);
        bus.in_a = 16'h5400; bus.in_b = 16'h3C01; bus.in_valid = 1'b1;
        chk("full_in_ready", bus.in_ready, 0);
        e = mk(0,0,5'd21,16'h8000,16'h8020,4'd6,0,0,1);
        q.push_back(e);
        repeat (2) @(posedge clk);
        #1 chk("stall_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(negedge clk) chk("stream_valid0", bus.out_valid, 1);
        @(posedge clk); #1 bus.in_valid = 1'b0;
        @(negedge clk) chk("stream_valid1", bus.out_valid, 1);
        @(negedge clk) chk("stream_valid2", bus.out_valid, 1);
        drain();

        // Asynchronous reset between edges with both stages full.
        bus.out_ready = 1'b0;
        send(16'h3C00, 16'h3800, mk(0,0,5'd15,16'h8000,16'h8000,4'd1,0,0,0), 1);
        send(16'h3800, 16'hC000, mk(1,0,5'd16,16'h8000,16'h8000,4'd2,0,1,0), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", bus.out_valid, 0);
        chk("async_in_ready", bus.in_ready, 1);
        chk("async_big_man", bus.out_big_man, 0);
        q.delete();
        presented = 0;
        #4 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk) chk("post_rst_idle", bus.out_valid, 0);
        @(posedge clk); #1;
        send(16'h7800, 16'h0400, mk(0,0,5'd30,16'h8000,16'h0000,4'd15,1,0,1), 1);
        drain();
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
